// File: rtl/cnn_pkg.sv
// Shared types and constants for the CNN bring-up load sequencer.
// Region order matches the parameter-memory select encoding used by the AHB write path.
package cnn_pkg;

    typedef enum logic [2:0] {
        L1_W  = 3'd0,
        L1_B  = 3'd1,
        L2_W1 = 3'd2,
        L2_B1 = 3'd3,
        L2_W2 = 3'd4,
        V_W   = 3'd5,
        V_B   = 3'd6
    } region_t;

    localparam int NUM_REGIONS = 7;
    localparam logic [9:0] REGION_WORDS [NUM_REGIONS] = '{
        10'd36, 10'd4, 10'd144, 10'd8, 10'd144, 10'd768, 10'd6
    };
    localparam int TOTAL_WORDS = 1110;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_REQ,
        ST_LOAD_WAIT,
        ST_LOAD_WR,
        ST_RST_CNN,
        ST_RUN,
        ST_DONE,
        ST_ERROR
    } state_t;

endpackage

// File: rtl/cnn_region_counter.sv
// Walks region/index/global-word position through the seven parameter memories.
// last flags the final word of V_B so the sequencer can leave the load loop.
module cnn_region_counter
    import cnn_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        advance,
    output logic [2:0]  sel,
    output logic [9:0]  idx,
    output logic [10:0] word,
    output logic        last
);

    logic [9:0] region_end;

    assign region_end = REGION_WORDS[sel] - 10'd1;
    assign last       = (sel == V_B) && (idx == region_end);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel  <= 3'd0;
            idx  <= 10'd0;
            word <= 11'd0;
        end else if (clear) begin
            sel  <= 3'd0;
            idx  <= 10'd0;
            word <= 11'd0;
        end else if (advance) begin
            word <= word + 11'd1;
            if (idx == region_end) begin
                idx <= 10'd0;
                // Wrap instead of stepping past V_B so the region table is never over-indexed
                sel <= (sel == V_B) ? 3'd0 : sel + 3'd1;
            end else begin
                idx <= idx + 10'd1;
            end
        end
    end

endmodule

// File: rtl/cnn_load_sequencer.sv
// Bring-up sequencer: streams parameters from source memory into the CNN, then
// runs the CNN until VALID or timeout and reports the outcome to the host.
module cnn_load_sequencer
    import cnn_pkg::*;
#(
    parameter int DW             = 16,
    parameter int SRC_AW         = 16,
    parameter int RST_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              START,
    input  logic              SKIP_LOAD,
    input  logic              ABORT,
    input  logic [SRC_AW-1:0] SRC_BASE,
    output logic              SRC_REQ,
    output logic [SRC_AW-1:0] SRC_ADDR,
    input  logic              SRC_GNT,
    input  logic              SRC_RVALID,
    input  logic [DW-1:0]     SRC_RDATA,
    output logic              PW_EN,
    output logic [2:0]        PW_SEL,
    output logic [9:0]        PW_ADDR,
    output logic [DW-1:0]     PW_DATA,
    output logic              CNN_RSTn,
    output logic              CNN_EN,
    input  logic              CNN_VALID,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR,
    output logic              IRQ
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t            state;
    state_t            state_nx;
    logic [SRC_AW-1:0] base_q;
    logic [3:0]        rst_cnt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              idle_like;
    logic              start_ok;
    logic              cnt_adv;
    logic              rst_done;
    logic              tmo_hit;
    logic              capture;
    logic [2:0]        rc_sel;
    logic [9:0]        rc_idx;
    logic [10:0]       rc_word;
    logic              rc_last;

    assign idle_like = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR);
    assign start_ok  = START && !ABORT && idle_like;
    assign cnt_adv   = (state == ST_LOAD_WR) && !ABORT;
    assign rst_done  = (rst_cnt == 4'(RST_CYCLES - 1));
    assign tmo_hit   = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
    assign capture   = (state == ST_LOAD_WAIT) && SRC_RVALID && !ABORT;
    assign SRC_ADDR  = base_q + SRC_AW'(rc_word);

    cnn_region_counter u_region_counter (
        .clk     (HCLK),
        .rst_n   (HRESETn),
        .clear   (start_ok),
        .advance (cnt_adv),
        .sel     (rc_sel),
        .idx     (rc_idx),
        .word    (rc_word),
        .last    (rc_last)
    );

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        SRC_REQ  = 1'b0;
        CNN_RSTn = 1'b0;
        CNN_EN   = 1'b0;
        BUSY     = 1'b1;
        DONE     = 1'b0;
        ERR      = 1'b0;
        case (state)
            ST_IDLE: begin
                BUSY = 1'b0;
                if (START) state_nx = SKIP_LOAD ? ST_RST_CNN : ST_LOAD_REQ;
            end
            ST_LOAD_REQ: begin
                SRC_REQ = 1'b1;
                if (SRC_GNT) state_nx = ST_LOAD_WAIT;
            end
            ST_LOAD_WAIT: begin
                if (SRC_RVALID) state_nx = ST_LOAD_WR;
            end
            ST_LOAD_WR: begin
                state_nx = rc_last ? ST_RST_CNN : ST_LOAD_REQ;
            end
            ST_RST_CNN: begin
                if (rst_done) state_nx = ST_RUN;
            end
            ST_RUN: begin
                CNN_RSTn = 1'b1;
                CNN_EN   = 1'b1;
                // VALID on the last allowed cycle still counts as success
                if (CNN_VALID)    state_nx = ST_DONE;
                else if (tmo_hit) state_nx = ST_ERROR;
            end
            ST_DONE: begin
                // Keep the CNN out of reset so its output registers stay readable
                CNN_RSTn = 1'b1;
                CNN_EN   = 1'b1;
                BUSY     = 1'b0;
                DONE     = 1'b1;
                if (START) state_nx = SKIP_LOAD ? ST_RST_CNN : ST_LOAD_REQ;
            end
            ST_ERROR: begin
                BUSY = 1'b0;
                ERR  = 1'b1;
                if (START) state_nx = SKIP_LOAD ? ST_RST_CNN : ST_LOAD_REQ;
            end
            default: state_nx = ST_IDLE;
        endcase
        if (ABORT) state_nx = ST_IDLE;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            base_q  <= '0;
            rst_cnt <= '0;
            tmo_cnt <= '0;
            PW_EN   <= 1'b0;
            PW_SEL  <= 3'd0;
            PW_ADDR <= 10'd0;
            PW_DATA <= '0;
            IRQ     <= 1'b0;
        end else begin
            if (start_ok) base_q <= SRC_BASE;
            rst_cnt <= (state == ST_RST_CNN && !rst_done) ? rst_cnt + 4'd1 : 4'd0;
            tmo_cnt <= (state == ST_RUN) ? tmo_cnt + 1'b1 : '0;
            PW_EN   <= capture;
            if (capture) begin
                PW_SEL  <= rc_sel;
                PW_ADDR <= rc_idx;
                PW_DATA <= SRC_RDATA;
            end
            IRQ <= ((state_nx == ST_DONE) && (state != ST_DONE)) ||
                   ((state_nx == ST_ERROR) && (state != ST_ERROR));
        end
    end

endmodule
